cc_frame_uart_tx: RTL and testbench
===================================

# cc_frame_uart_tx

Parametrised frame serialiser for the CC link. On a start request it reads `frame_len` words from a synchronous-read buffer RAM, starting at address 0, and sends each word as an asynchronous serial character on `tx`: LSB first, with optional parity and 1 or 2 stop bits. Frame length is supplied at run time. The block drives busy/done status to the frame producer and supports a graceful abort at character boundaries.

## Interface
- `ADDR_W`, 12: buffer address width; maximum frame is 2^ADDR_W words.
- `DATA_W`, 8: character data bits, legal 5..9.
- `CLKS_PER_BIT`, 49: clock cycles per serial bit, legal ≥2.
- `STOP_BITS`, 1: legal values 1 or 2.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `GAP_CLKS`, 0: extra idle-high cycles inserted between characters.

- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  frame request, sampled only in IDLE.
- `abort`  in  1  stop after the current character.
- `frame_len`  in  ADDR_W+1  number of words to send, latched at start.
- `rdaddress`  out  ADDR_W  buffer read address, registered.
- `data`  in  DATA_W  buffer read data, valid 1 cycle after `rdaddress`.
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  high from the cycle after start acceptance until done.
- `done`  out  1  one-cycle pulse at frame end.
- `byte_count`  out  ADDR_W+1  characters fully sent in the current or last frame.

## Operation
- **Reset values:** `tx`=1, `busy`=0, `done`=0, `rdaddress`=0, `byte_count`=0. State returns to IDLE and all counters clear. A reset mid-character drives `tx` high immediately, because reset is asynchronous.
- **States:** IDLE, FETCH, LOAD, START, DATA, PAR, STOP, GAP, DONE.
- **IDLE:** `tx`=1. When `start`=1:
  - latch `frame_len`, clear `byte_count` and `rdaddress`, set `busy`.
  - If latched length is 0, go to DONE; otherwise go to FETCH.
- **FETCH:** one-cycle wait for RAM read latency.
- **LOAD:**
  - Capture `data` into the shift register.
  - Compute parity: odd means the XOR of the data bits, inverted; even means the XOR of the data bits.
  - Increment `rdaddress`, wrapping mod 2^ADDR_W.
  - Set `tx` to 0 and go to START.
- **START:** hold `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA:** each bit is driven for CLKS_PER_BIT cycles, LSB first, for DATA_W bits. Then go to PAR if PARITY≠0, else STOP.
- **PAR:** parity bit for CLKS_PER_BIT cycles.
- **STOP:** `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles. On exit, increment `byte_count`. Next state:
  - DONE if `byte_count`+1 == latched length, or if an abort is pending.
  - GAP if GAP_CLKS>0.
  - FETCH otherwise.
- **GAP:** `tx`=1 for GAP_CLKS cycles, then go to FETCH.
- **DONE:**
  - `done`=1 for one cycle, `busy`=0.
  - `tx`=1, and `rdaddress` keeps its final value.
  - Return to IDLE.
- **Abort:**
  - An `abort` pulse in any non-IDLE state sets a sticky pending flag.
  - The current character always completes through its stop bits.
  - The pending flag clears in DONE.
  - `abort` in IDLE is ignored.
- **Start handling:** `start` while `busy` is ignored. `start` and `abort` together in IDLE: the start is accepted and the abort is ignored.
- **Ordering:** `rdaddress` and `byte_count` never run past the latched length. A length of 2^ADDR_W sends the whole buffer.

## Timing
- **Start acceptance:** the start-accept edge is T0 (IDLE sees `start`=1).
  - FETCH occupies T0→T1 and LOAD occupies T1→T2.
  - `tx` falls at edge T2.
- **Character period:** (1 + DATA_W + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- **Character spacing:** `tx` is high for STOP_BITS×CLKS_PER_BIT + GAP_CLKS + 2 cycles between consecutive characters.
- **Status timing:**
  - `busy` rises at T0 and falls with the `done` pulse.
  - `done` is asserted the cycle after the last STOP cycle.
  - For a zero-length frame, `done` is asserted at T1 and `tx` never leaves 1.
- **Counter update:** `byte_count` updates on the same edge that ends STOP.

## Test plan
- **Basic frame:** CLKS_PER_BIT=4, defaults otherwise, RAM = 0x55, 0xA3, 0x0F, `frame_len`=3, start pulse.
  - `tx` shows 3 characters of 40 cycles each.
  - Bits decode to 0x55, 0xA3, 0x0F.
  - Reads use `rdaddress` 0, 1, 2; `done` pulses once; `byte_count`=3.
- **Parity and stop bits:** PARITY=2, STOP_BITS=2, data 0x07.
  - Parity bit is 1; stop is high for 8 cycles.
  - Repeat with PARITY=1: parity bit is 0.
- **Zero length:** `frame_len`=0 → `done` at T1, `tx` stays 1, `byte_count`=0.
- **Abort:** `frame_len`=10, `abort` pulsed mid-DATA of character 2.
  - Character 2 completes; `done` follows its stop.
  - `byte_count`=2 and no third start bit appears.
- **Restart and reset:** `start` re-pulsed while busy → ignored, frame length unchanged.
  - Reset asserted mid-START → `tx`=1 that cycle, all outputs at reset values.
  - A subsequent start sends from address 0.
- **Gap and wrap:** GAP_CLKS=5, ADDR_W=2, `frame_len`=4.
  - Inter-character high time is 4+5+2 = 11 cycles.
  - `rdaddress` ends at 0 (wrapped); `byte_count`=4.

Source files
------------

// File: rtl/cc_frame_uart_tx.sv
// Frame serialiser: streams frame_len words from a sync-read buffer onto tx as UART characters.
// First start bit 2 cycles after start acceptance; abort stops the frame at the next character boundary.
module cc_frame_uart_tx #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 49,
    parameter int STOP_BITS    = 1,
    parameter int PARITY       = 0,
    parameter int GAP_CLKS     = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   frame_len,
    output logic [ADDR_W-1:0] rdaddress,
    input  logic [DATA_W-1:0] data,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   byte_count
);
    localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    localparam int GAP_LAST  = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;
    localparam int CNT_MAX   = (STOP_CLKS > GAP_CLKS) ? STOP_CLKS : GAP_CLKS;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int BIT_W     = $clog2(DATA_W);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PAR, S_STOP, S_GAP, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [BIT_W-1:0]  bit_idx, bit_idx_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic              par_bit, par_bit_nxt;
    logic [ADDR_W:0]   len_q, len_nxt;
    logic              abort_pend, abort_pend_nxt;
    logic              tx_nxt, busy_nxt, done_nxt;
    logic [ADDR_W-1:0] rdaddress_nxt;
    logic [ADDR_W:0]   byte_count_nxt, byte_inc;
    logic              bit_end;

    assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            len_q      <= '0;
            abort_pend <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdaddress  <= '0;
            byte_count <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shreg      <= shreg_nxt;
            par_bit    <= par_bit_nxt;
            len_q      <= len_nxt;
            abort_pend <= abort_pend_nxt;
            tx         <= tx_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            rdaddress  <= rdaddress_nxt;
            byte_count <= byte_count_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt + CNT_W'(1);
        bit_idx_nxt    = bit_idx;
        shreg_nxt      = shreg;
        par_bit_nxt    = par_bit;
        len_nxt        = len_q;
        tx_nxt         = tx;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        rdaddress_nxt  = rdaddress;
        byte_count_nxt = byte_count;
        abort_pend_nxt = abort_pend | (abort && (state != S_IDLE));
        byte_inc       = byte_count + (ADDR_W + 1)'(1);

        case (state)
            S_IDLE: begin
                tx_nxt  = 1'b1;
                cnt_nxt = '0;
                if (start) begin
                    len_nxt        = frame_len;
                    byte_count_nxt = '0;
                    rdaddress_nxt  = '0;
                    busy_nxt       = 1'b1;
                    state_nxt      = (frame_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD: begin
                shreg_nxt     = data;
                par_bit_nxt   = (PARITY == 1) ? ~(^data) : ^data;
                rdaddress_nxt = rdaddress + ADDR_W'(1);
                tx_nxt        = 1'b0;
                cnt_nxt       = '0;
                state_nxt     = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    cnt_nxt     = '0;
                    tx_nxt      = shreg[0];
                    shreg_nxt   = shreg >> 1;
                    bit_idx_nxt = '0;
                    state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_nxt = '0;
                    if (bit_idx == BIT_W'(DATA_W - 1)) begin
                        if (PARITY != 0) begin
                            tx_nxt    = par_bit;
                            state_nxt = S_PAR;
                        end else begin
                            tx_nxt    = 1'b1;
                            state_nxt = S_STOP;
                        end
                    end else begin
                        tx_nxt      = shreg[0];
                        shreg_nxt   = shreg >> 1;
                        bit_idx_nxt = bit_idx + BIT_W'(1);
                    end
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    tx_nxt    = 1'b1;
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                // Character boundary: the only place a frame may end early.
                if (cnt == CNT_W'(STOP_CLKS - 1)) begin
                    cnt_nxt        = '0;
                    byte_count_nxt = byte_inc;
                    if (byte_inc == len_q || abort_pend || abort)
                        state_nxt = S_DONE;
                    else if (GAP_CLKS > 0)
                        state_nxt = S_GAP;
                    else
                        state_nxt = S_FETCH;
                end
            end
            S_GAP: begin
                if (cnt == CNT_W'(GAP_LAST)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_FETCH;
                end
            end
            S_DONE: begin
                done_nxt       = 1'b1;
                busy_nxt       = 1'b0;
                tx_nxt         = 1'b1;
                abort_pend_nxt = 1'b0;
                state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_cc_frame_uart_tx.sv
// Bench for cc_frame_uart_tx: four parameterisations checked against a per-cycle waveform model
// built from the character framing rules, plus a line decoder and directed reset/abort sequences.
module tb_cc_frame_uart_tx;
    localparam int CPB = 4;
    localparam int NK  = 4;

    typedef struct {
        int k;
        int len;
        int abort_char;
        int restart_cyc;
        int exp_bytes;
        int exp_ra;
        int exp_par;
        int exp_hi;
    } vec_t;

    typedef struct {
        logic tx;
        logic busy;
        logic done;
        int   bc;
        int   ra;
    } cyc_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             abort;
    logic [3:0]       start_v;
    logic [12:0]      frame_len;
    logic [3:0][7:0]  data_v;
    wire  [3:0]       tx_v, busy_v, done_v;
    wire  [3:0][11:0] ra_v;
    wire  [3:0][12:0] bc_v;
    wire  [1:0]       ra3;
    wire  [2:0]       bc3;
    logic [7:0]       ram [NK][4096];
    int               total, bad;
    vec_t             tbl [9];

    assign ra_v[3] = {10'd0, ra3};
    assign bc_v[3] = {10'd0, bc3};

    always #5 clock = ~clock;

    always @(posedge clock) begin
        for (int k = 0; k < NK; k++) data_v[k] <= ram[k][ra_v[k]];
    end

    cc_frame_uart_tx #(.CLKS_PER_BIT(CPB)) u_dut0 (
        .clock(clock), .reset(reset), .start(start_v[0]), .abort(abort), .frame_len(frame_len),
        .rdaddress(ra_v[0]), .data(data_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .byte_count(bc_v[0]));
    cc_frame_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) u_dut1 (
        .clock(clock), .reset(reset), .start(start_v[1]), .abort(abort), .frame_len(frame_len),
        .rdaddress(ra_v[1]), .data(data_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .byte_count(bc_v[1]));
    cc_frame_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) u_dut2 (
        .clock(clock), .reset(reset), .start(start_v[2]), .abort(abort), .frame_len(frame_len),
        .rdaddress(ra_v[2]), .data(data_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .byte_count(bc_v[2]));
    cc_frame_uart_tx #(.ADDR_W(2), .CLKS_PER_BIT(CPB), .GAP_CLKS(5)) u_dut3 (
        .clock(clock), .reset(reset), .start(start_v[3]), .abort(abort), .frame_len(frame_len[2:0]),
        .rdaddress(ra3), .data(data_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]),
        .byte_count(bc3));

    function automatic int p_stop(input int k);  return (k == 1 || k == 2) ? 2 : 1; endfunction
    function automatic int p_par(input int k);   return (k == 1) ? 2 : ((k == 2) ? 1 : 0); endfunction
    function automatic int p_gap(input int k);   return (k == 3) ? 5 : 0; endfunction
    function automatic int p_depth(input int k); return (k == 3) ? 4 : 4096; endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag, input int k);
        check($sformatf("%s_k%0d_tx_busy_done", tag, k),
              int'(tx_v[k]) * 4 + int'(busy_v[k]) * 2 + int'(done_v[k]), 4);
        check($sformatf("%s_k%0d_ra_bc", tag, k), int'(ra_v[k]) + int'(bc_v[k]), 0);
    endtask

    task automatic run_frame(input vec_t v);
        cyc_t q[$];
        cyc_t c;
        logic cap[$];
        logic [7:0] d, dec;
        int bc, ra, nch, abort_cyc, act, exp, period, nstart, idx, run;
        bit frame_bad;
        bc = 0; ra = 0; abort_cyc = -1; frame_bad = 0;
        nch = (v.abort_char >= 0) ? v.abort_char + 1 : v.len;
        c.tx = 1'b1; c.busy = 1'b1; c.done = 1'b0; c.bc = 0; c.ra = 0;
        // Expected line/status per cycle, starting with the cycle after the accept edge.
        for (int j = 0; j < nch; j++) begin
            c.tx = 1'b1; c.bc = bc; c.ra = ra;
            q.push_back(c); q.push_back(c);
            ra = (ra + 1) % p_depth(v.k);
            c.ra = ra;
            d = ram[v.k][j % p_depth(v.k)];
            if (j == v.abort_char) abort_cyc = q.size() + 3 * CPB;
            c.tx = 1'b0; repeat (CPB) q.push_back(c);
            for (int b = 0; b < 8; b++) begin
                c.tx = d[b]; repeat (CPB) q.push_back(c);
            end
            if (p_par(v.k) != 0) begin
                c.tx = (p_par(v.k) == 2) ? ^d : ~(^d);
                repeat (CPB) q.push_back(c);
            end
            c.tx = 1'b1; repeat (CPB * p_stop(v.k)) q.push_back(c);
            bc++; c.bc = bc;
            if (j < nch - 1) repeat (p_gap(v.k)) q.push_back(c);
        end
        c.tx = 1'b1; c.bc = bc; c.ra = ra;
        q.push_back(c);
        c.busy = 1'b0; c.done = 1'b1; q.push_back(c);
        c.done = 1'b0; q.push_back(c);

        @(negedge clock);
        frame_len = 13'(v.len);
        start_v[v.k] = 1'b1;
        @(negedge clock);
        start_v[v.k] = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            act = (int'(ra_v[v.k]) << 16) | (int'(bc_v[v.k]) << 3) |
                  (int'(tx_v[v.k]) << 2) | (int'(busy_v[v.k]) << 1) | int'(done_v[v.k]);
            exp = (q[i].ra << 16) | (q[i].bc << 3) | (int'(q[i].tx) << 2) |
                  (int'(q[i].busy) << 1) | int'(q[i].done);
            if (!frame_bad) begin
                check($sformatf("k%0d_len%0d_cycle%0d", v.k, v.len, i), act, exp);
                if (act != exp) frame_bad = 1;
            end
            cap.push_back(tx_v[v.k]);
            abort = (i == abort_cyc);
            if (i == v.restart_cyc) begin
                start_v[v.k] = 1'b1;
                frame_len = 13'(v.len + 7);
            end else begin
                start_v[v.k] = 1'b0;
            end
            @(negedge clock);
        end
        abort = 1'b0;

        check($sformatf("k%0d_final_byte_count", v.k), int'(bc_v[v.k]), v.exp_bytes);
        check($sformatf("k%0d_final_rdaddress", v.k), int'(ra_v[v.k]), v.exp_ra);

        // Independent line decode: find start bits, sample data at bit centres.
        period = CPB * (1 + 8 + ((p_par(v.k) != 0) ? 1 : 0) + p_stop(v.k));
        nstart = 0;
        idx = 1;
        while (idx < cap.size()) begin
            if (cap[idx - 1] == 1'b1 && cap[idx] == 1'b0) begin
                dec = '0;
                for (int b = 0; b < 8; b++) begin
                    if (idx + CPB * (1 + b) + CPB / 2 < cap.size())
                        dec[b] = cap[idx + CPB * (1 + b) + CPB / 2];
                end
                check($sformatf("k%0d_decode_char%0d", v.k, nstart), int'(dec),
                      int'(ram[v.k][nstart % p_depth(v.k)]));
                nstart++;
                idx += period - 1;
            end
            idx++;
        end
        check($sformatf("k%0d_start_bits", v.k), nstart, v.exp_bytes);

        if (v.exp_par >= 0 && 2 + CPB * 9 + CPB / 2 < cap.size())
            check($sformatf("k%0d_parity_bit", v.k), int'(cap[2 + CPB * 9 + CPB / 2]), v.exp_par);
        if (v.exp_hi >= 0) begin
            idx = 2 + CPB * 9;
            run = 0;
            while (idx < cap.size() && cap[idx] == 1'b1) begin
                run++;
                idx++;
            end
            check($sformatf("k%0d_inter_char_high", v.k), run, v.exp_hi);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        int n;
        total = 0; bad = 0;
        reset = 1'b1; abort = 1'b0; start_v = '0; frame_len = '0;
        for (int k = 0; k < NK; k++)
            for (int a = 0; a < 4096; a++) ram[k][a] = 8'($urandom);
        ram[0][0] = 8'h55; ram[0][1] = 8'hA3; ram[0][2] = 8'h0F;
        ram[1][0] = 8'h07; ram[2][0] = 8'h07;
        ram[3][0] = 8'h55; ram[3][1] = 8'h23; ram[3][2] = 8'h0F; ram[3][3] = 8'h3C;

        repeat (3) @(negedge clock);
        for (int k = 0; k < NK; k++) check_reset_state("reset", k);
        reset = 1'b0;
        @(negedge clock);

        //        k len abort restart bytes ra par hi
        tbl[0] = '{0,  3, -1, -1, 3, 3, -1, -1};
        tbl[1] = '{1,  1, -1, -1, 1, 1,  1, -1};
        tbl[2] = '{2,  1, -1, -1, 1, 1,  0, -1};
        tbl[3] = '{0,  0, -1, -1, 0, 0, -1, -1};
        tbl[4] = '{0, 10,  1, -1, 2, 2, -1, -1};
        tbl[5] = '{3,  4, -1, -1, 4, 0, -1, 11};
        tbl[6] = '{0,  2, -1, 30, 2, 2, -1, -1};
        tbl[7] = '{1,  3, -1, -1, 3, 3, -1, -1};
        tbl[8] = '{3,  3, -1,  5, 3, 3, -1, -1};
        for (int r = 0; r < 9; r++) run_frame(tbl[r]);

        // Reset while the first start bit is on the line.
        @(negedge clock);
        frame_len = 13'd3;
        start_v[0] = 1'b1;
        @(negedge clock);
        start_v[0] = 1'b0;
        n = 0;
        while (tx_v[0] !== 1'b0 && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("reset_test_tx_fell", int'(n < 10), 1);
        @(negedge clock);
        check("reset_test_tx_low_before", int'(tx_v[0]), 0);
        #2 reset = 1'b1;
        #1 check_reset_state("mid_start_reset", 0);
        @(negedge clock);
        reset = 1'b0;
        run_frame(tbl[0]);

        for (int r = 0; r < 4; r++) begin
            rv.k = int'($urandom_range(0, 3));
            rv.len = (rv.k == 3) ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 6));
            rv.abort_char = -1; rv.restart_cyc = -1; rv.exp_par = -1; rv.exp_hi = -1;
            if (rv.len >= 2 && $urandom_range(0, 1) == 1)
                rv.abort_char = int'($urandom_range(0, rv.len - 2));
            rv.exp_bytes = (rv.abort_char >= 0) ? rv.abort_char + 1 : rv.len;
            rv.exp_ra = rv.exp_bytes % p_depth(rv.k);
            run_frame(rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
